// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI mode-0 master for the ADXL362. After the first sample tick it writes
// POWER_CTL=measure, then on every later tick reads XDATA/YDATA (8-bit) and presents them
// as offset-binary bytes (0x80 = level).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   spi_miso     in   accelerometer data, sampled as spi_sclk rises
//   spi_sclk     out  SPI clock, idles low
//   spi_mosi     out  command/address/data, MSB first, changes as spi_sclk falls
//   spi_cs_n     out  chip select, active low
//   accelX_OUT   out  latest X sample, offset binary
//   accelY_OUT   out  latest Y sample, offset binary
//   sample_valid out  one-clk pulse when X and Y update together
//   init_done    out  set once the configuration write has completed
module accel_spi_reader #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned SCLK_FREQUENCY_HZ      = 1000000,
  parameter int unsigned SAMPLE_FREQUENCY_HZ    = 100,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter bit          SIMULATE               = 1'b0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic [7:0] accelX_OUT,
  output logic [7:0] accelY_OUT,
  output logic       sample_valid,
  output logic       init_done
);

  localparam int unsigned HalfCnt = SIMULATE ? 1 : CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ) - 1;
  localparam int unsigned TickCnt = SIMULATE ? SIMULATE_FREQUENCY_CNT
                                             : CLK_FREQUENCY_HZ / SAMPLE_FREQUENCY_HZ - 1;
  localparam logic [15:0]           HalfTop = 16'(HalfCnt);
  localparam logic [CNTR_WIDTH-1:0] TickTop = CNTR_WIDTH'(TickCnt);

  // Frames are left-aligned: write 0x0A / POWER_CTL 0x2D / measure 0x02, and
  // read 0x0B / XDATA 0x08 followed by two dummy bytes.
  localparam logic [31:0] CfgWord  = 32'h0A2D_0200;
  localparam logic [31:0] ReadWord = 32'h0B08_0000;

  typedef enum logic [2:0] {StWaitStart, StCfg, StIdle, StRead, StUpdate, StGap} state_e;

  state_e                r_state;
  logic [CNTR_WIDTH-1:0] r_tick_cnt;
  logic [15:0]           r_half_cnt;
  logic [4:0]            r_bit;
  logic                  r_tail;
  logic [30:0]           r_tx;   // bits still to send after the one on spi_mosi
  logic [15:0]           r_rx;   // last 16 MISO bits = {X, Y} at the end of a read

  logic       w_tick;
  logic       w_half_done;
  logic [4:0] w_last_bit;

  assign w_tick      = (r_tick_cnt == TickTop);
  assign w_half_done = (r_half_cnt == HalfTop);
  assign w_last_bit  = (r_state == StCfg) ? 5'd23 : 5'd31;

  // Free-running sample tick; ticks seen outside WAIT_START/IDLE are simply ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StWaitStart;
      r_half_cnt   <= '0;
      r_bit        <= '0;
      r_tail       <= 1'b0;
      r_tx         <= '0;
      r_rx         <= '0;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_cs_n     <= 1'b1;
      accelX_OUT   <= 8'h80;
      accelY_OUT   <= 8'h80;
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (r_state)
        StWaitStart, StIdle: begin
          if (w_tick) begin
            // cs_n drops here, a half-period ahead of the first rising sclk.
            r_state    <= (r_state == StWaitStart) ? StCfg : StRead;
            spi_cs_n   <= 1'b0;
            spi_mosi   <= (r_state == StWaitStart) ? CfgWord[31] : ReadWord[31];
            r_tx       <= (r_state == StWaitStart) ? CfgWord[30:0] : ReadWord[30:0];
            r_half_cnt <= '0;
            r_bit      <= '0;
            r_tail     <= 1'b0;
          end
        end
        StCfg, StRead: begin
          if (!w_half_done) begin
            r_half_cnt <= r_half_cnt + 16'd1;
          end else begin
            r_half_cnt <= '0;
            if (r_tail) begin
              // Trailing low half-period done: release chip select.
              spi_cs_n <= 1'b1;
              r_tail   <= 1'b0;
              r_bit    <= '0;
              if (r_state == StCfg) begin
                init_done <= 1'b1;
                r_state   <= StGap;
              end else begin
                r_state <= StUpdate;
              end
            end else if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              r_rx     <= {r_rx[14:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (r_bit == w_last_bit) begin
                r_tail   <= 1'b1;
                spi_mosi <= 1'b0;
              end else begin
                r_bit    <= r_bit + 5'd1;
                spi_mosi <= r_tx[30];
                r_tx     <= {r_tx[29:0], 1'b0};
              end
            end
          end
        end
        StUpdate: begin
          // Flipping the sign bit maps two's complement onto offset binary.
          accelX_OUT   <= {~r_rx[15], r_rx[14:8]};
          accelY_OUT   <= {~r_rx[7], r_rx[6:0]};
          sample_valid <= 1'b1;
          r_half_cnt   <= '0;
          r_bit        <= '0;
          r_state      <= StGap;
        end
        StGap: begin
          // Four half-periods = two full SCLK periods with cs_n high.
          if (!w_half_done) begin
            r_half_cnt <= r_half_cnt + 16'd1;
          end else begin
            r_half_cnt <= '0;
            if (r_bit == 5'd3) begin
              r_bit   <= '0;
              r_state <= StIdle;
            end else begin
              r_bit <= r_bit + 5'd1;
            end
          end
        end
        default: r_state <= StWaitStart;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader (SIMULATE=1): an ADXL362-like slave serves X/Y vectors, a
// frame-level model predicts outputs, and one negedge process compares every cycle.
module tb_accel_spi_reader;

  localparam int NVec = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_miso = 1'b0;
  logic       spi_sclk, spi_mosi, spi_cs_n, sample_valid, init_done;
  logic [7:0] accel_x, accel_y;

  int n_checks = 0;
  int n_errors = 0;

  // Slave data per read frame; entry 3 is served twice (aborted by reset, then reissued).
  logic [7:0] vec_x [NVec] = '{8'h10, 8'h7F, 8'hA5, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00};
  logic [7:0] vec_y [NVec] = '{8'hF0, 8'h80, 8'h3C, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00};

  // Model / slave state, written only by the compare process.
  int          idx = 0;
  int          nbits = 0;
  int          hi_run = 0;
  bit          cfg_seen = 1'b0;
  bit          first_frame = 1'b1;
  bit          upd_due = 1'b0;
  bit          prev_cs = 1'b1;
  bit          prev_sclk = 1'b0;
  logic [31:0] rx_frame = '0;
  logic [31:0] miso_frame = '0;
  logic [7:0]  px = '0, py = '0;
  logic [7:0]  exp_x = 8'h80, exp_y = 8'h80;
  bit          exp_valid = 1'b0;
  bit          exp_init = 1'b0;

  accel_spi_reader #(
    .CLK_FREQUENCY_HZ      (100000000),
    .SCLK_FREQUENCY_HZ     (1000000),
    .SAMPLE_FREQUENCY_HZ   (100),
    .CNTR_WIDTH            (32),
    .SIMULATE              (1'b1),
    .SIMULATE_FREQUENCY_CNT(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_miso    (spi_miso),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .accelX_OUT  (accel_x),
    .accelY_OUT  (accel_y),
    .sample_valid(sample_valid),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_offset(input logic [7:0] s);
    return 8'(int'($signed(s)) + 128);
  endfunction

  // Slave + model + per-cycle comparison.
  always @(negedge clk) begin
    if (!reset) begin
      exp_x = 8'h80; exp_y = 8'h80; exp_valid = 1'b0; exp_init = 1'b0;
      upd_due = 1'b0; cfg_seen = 1'b0; first_frame = 1'b1; nbits = 0; hi_run = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; spi_miso = 1'b0;
      check(spi_cs_n === 1'b1, "rst_cs_n", spi_cs_n, 1);
      check(spi_mosi === 1'b0, "rst_mosi", spi_mosi, 0);
    end else begin
      exp_valid = 1'b0;
      if (upd_due) begin
        exp_x = to_offset(px);
        exp_y = to_offset(py);
        exp_valid = 1'b1;
        upd_due = 1'b0;
      end
      if (prev_cs && !spi_cs_n) begin
        if (!first_frame) check(hi_run >= 8, "cs_gap", hi_run, 8);
        nbits = 0;
        rx_frame = '0;
        miso_frame = cfg_seen ? {16'h0000, vec_x[idx], vec_y[idx]} : 32'h0;
        spi_miso = miso_frame[31];
      end
      if (!spi_cs_n && !prev_sclk && spi_sclk) begin
        rx_frame = {rx_frame[30:0], spi_mosi};
        nbits++;
      end
      if (!spi_cs_n && prev_sclk && !spi_sclk && nbits < 32) spi_miso = miso_frame[31 - nbits];
      if (!prev_cs && spi_cs_n) begin
        if (!cfg_seen) begin
          check(nbits == 24, "cfg_bits", nbits, 24);
          check(rx_frame[23:0] == 24'h0A2D02, "cfg_mosi", rx_frame[23:0], 24'h0A2D02);
          cfg_seen = 1'b1;
          exp_init = 1'b1;
        end else begin
          check(nbits == 32, "read_bits", nbits, 32);
          check(rx_frame == 32'h0B080000, "read_mosi", rx_frame, 32'h0B080000);
          px = vec_x[idx];
          py = vec_y[idx];
          if (idx < NVec - 1) idx++;
          upd_due = 1'b1;
        end
        first_frame = 1'b0;
        hi_run = 0;
      end
      if (spi_cs_n) hi_run++;
      prev_cs = spi_cs_n;
      prev_sclk = spi_sclk;
    end
    if (spi_cs_n) check(spi_sclk === 1'b0, "sclk_idle", spi_sclk, 0);
    check(accel_x === exp_x, "accel_x", accel_x, exp_x);
    check(accel_y === exp_y, "accel_y", accel_y, exp_y);
    check(sample_valid === exp_valid, "sample_valid", sample_valid, exp_valid);
    check(init_done === exp_init, "init_done", init_done, exp_init);
  end

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    check(seen, name, seen, 1);
  endtask

  task automatic wait_init();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) seen = 1'b1;
    end
    check(seen, "init_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(spi_cs_n === 1'b1, "lit_rst_cs", spi_cs_n, 1);
    check(accel_x === 8'h80, "lit_rst_x", accel_x, 8'h80);
    check(accel_y === 8'h80, "lit_rst_y", accel_y, 8'h80);
    @(posedge clk);
    #2 reset = 1'b1;

    wait_init();
    wait_valid("v0_timeout");
    check(accel_x === 8'h90, "lit_v0_x", accel_x, 8'h90);
    check(accel_y === 8'h70, "lit_v0_y", accel_y, 8'h70);
    wait_valid("v1_timeout");
    check(accel_x === 8'hFF, "lit_v1_x", accel_x, 8'hFF);
    check(accel_y === 8'h00, "lit_v1_y", accel_y, 8'h00);
    wait_valid("v2_timeout");
    check(accel_x === 8'h25, "lit_v2_x", accel_x, 8'h25);
    check(accel_y === 8'hBC, "lit_v2_y", accel_y, 8'hBC);

    // Abort the next read at bit 12 with an asynchronous reset.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cfg_seen && !spi_cs_n && nbits == 12) found = 1'b1;
    end
    check(found, "bit12_timeout", found, 1);
    #1 reset = 1'b0;
    #1;
    check(spi_cs_n === 1'b1, "abort_cs", spi_cs_n, 1);
    check(spi_sclk === 1'b0, "abort_sclk", spi_sclk, 0);
    check(accel_x === 8'h80, "abort_x", accel_x, 8'h80);
    check(init_done === 1'b0, "abort_init", init_done, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    wait_init();
    wait_valid("v3_timeout");
    check(accel_x === 8'h81, "lit_v3_x", accel_x, 8'h81);
    check(accel_y === 8'h7E, "lit_v3_y", accel_y, 8'h7E);
    wait_valid("v4_timeout");
    check(accel_x === 8'h00, "lit_v4_x", accel_x, 8'h00);
    check(accel_y === 8'hFF, "lit_v4_y", accel_y, 8'hFF);

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
- SPI master that configures the on-board ADXL362 accelerometer, then polls 8-bit X and Y tilt at a fixed rate.
- Presents X and Y as offset-binary bytes (0x80 = level) on accelX_OUT / accelY_OUT, which drive the accelX_IN / accelY_IN inputs of the ball position block.
- Producer end of the ball's accelerometer interface; runs on the system clock with no processor involvement.

Parameters:
- CLK_FREQUENCY_HZ, 100000000, system clock frequency.
- SCLK_FREQUENCY_HZ, 1000000, SPI clock rate. Half-period count is CLK/(2*SCLK)-1.
- SAMPLE_FREQUENCY_HZ, 100, poll rate. Tick count is CLK/SAMPLE-1.
- CNTR_WIDTH, 32, width of the sample-tick counter.
- SIMULATE, 0, 1 = use short counts.
- SIMULATE_FREQUENCY_CNT, 5, sample-tick top count when SIMULATE=1. The SCLK half-period count is 1 when SIMULATE=1.

Ports:
- clk, in, 1, system clock. All logic is on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- spi_miso, in, 1, accelerometer data out. Sampled on the rising edge of spi_sclk.
- spi_sclk, out, 1, SPI clock, mode 0. Idles low.
- spi_mosi, out, 1, data to the accelerometer, MSB first. Changes after the falling edge of spi_sclk.
- spi_cs_n, out, 1, chip select, active low.
- accelX_OUT, out, 8, latest X sample, offset binary.
- accelY_OUT, out, 8, latest Y sample, offset binary.
- sample_valid, out, 1, one-clk pulse when both outputs update together.
- init_done, out, 1, high once the configuration write has completed.

Behaviour:
- Reset (reset=0, asynchronous):
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - accelX_OUT=accelY_OUT=8'h80.
  - sample_valid=0, init_done=0.
  - State goes to WAIT_START; all counters are cleared.
  - A reset mid-transfer aborts immediately; cs_n rises asynchronously.
- Sample tick: a free-running counter pulses tick for 1 clk when it reaches top, then wraps to 0.
- States:
  - WAIT_START: on the first tick go to CFG.
  - CFG: cs_n=0 and shift 24 bits: 0x0A (write), 0x2D (POWER_CTL), 0x02 (measure). Then go to GAP with init_done set.
  - IDLE: on tick go to READ.
  - READ: cs_n=0 and shift 32 bits: 0x0B (read), 0x08 (XDATA), then 8 dummy zeros twice. Capture MISO bits 16-23 as X and bits 24-31 as Y. Then go to UPDATE.
  - UPDATE, 1 clk:
    - accelX_OUT = {~X[7], X[6:0]}; accelY_OUT = {~Y[7], Y[6:0]}. This converts two's complement to offset binary.
    - Pulse sample_valid, then go to GAP.
  - GAP: cs_n=1 for 2 full SCLK periods, then go to IDLE.
- Bit timing (per bit):
  - cs_n falls one half-period before the first rising SCLK edge.
  - MOSI holds the bit for a full period.
  - MISO is sampled on the clk where sclk goes 0->1.
  - After the last bit, sclk returns low and cs_n rises one half-period later.
- Bit counter: 5 bits, counts 0..N-1 with N = 24 or 32. No wrap beyond N.
- Tick during CFG, READ or GAP: it is dropped, not queued. A poll never overlaps a transfer.
- Outputs hold their value between updates.
- init_done stays 1 until the next reset.

Test Plan:
- Reset then release, SIMULATE=1 -> cs_n=1, outputs 0x80, sample_valid=0 until the first tick. Then exactly 24 SCLK pulses with MOSI bytes 0x0A, 0x2D, 0x02, followed by init_done=1.
- MISO model returns X=0x10, Y=0xF0 -> MOSI 0x0B, 0x08 over 32 clocks. Then accelX_OUT=0x90, accelY_OUT=0x70 with a single sample_valid pulse.
- X=0x7F, Y=0x80 (extremes) -> accelX_OUT=0xFF, accelY_OUT=0x00.
- Tick forced mid-READ -> transfer completes unchanged, no second transfer starts, and cs_n stays high for at least 2 SCLK periods between frames.
- Reset asserted on bit 12 of READ -> cs_n=1 and sclk=0 immediately, outputs 0x80, init_done=0. CFG is reissued after release.
- Back-to-back polls with changing MISO data -> each sample_valid is accompanied by the new X/Y, with no stale byte mixing.
